seven_seg_scanner: RTL and testbench

//  Parametrised multiplexed 7-segment driver; successor to the fixed 4-digit SevenSegment scanner.

---
 rtl/seven_seg_scanner.sv | 160 ++++++++++++++++
 tb/tb_seven_seg_scanner.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scanner.sv
// Multiplexed 7-segment scanner showing a loaded value as hex or as decimal.
// Decimal uses an iterative double-dabble converter, one bit per clock.
module seven_seg_scanner #(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV_W = 16,
    parameter int VALUE_W    = 14,
    parameter bit ACTIVE_LOW = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [VALUE_W-1:0]    value,
    input  logic                  load,
    input  logic                  mode,
    input  logic [NUM_DIGITS-1:0] dp_mask,
    input  logic                  blank_lz,
    output logic                  busy,
    output logic [7:0]            DISPLAY,
    output logic [NUM_DIGITS-1:0] DIGIT
);
    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int CNT_W = $clog2(VALUE_W + 1);

    function automatic longint unsigned pow10(input int n);
        longint unsigned r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    localparam longint unsigned MAX_DEC = pow10(NUM_DIGITS) - 1;
    localparam logic [7:0] DISP_OFF = ACTIVE_LOW ? 8'hFF : 8'h00;
    localparam logic [NUM_DIGITS-1:0] DIGIT_OFF = ACTIVE_LOW ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

    // Active-low gfedcba patterns; polarity is applied once at the output.
    function automatic logic [6:0] hex_seg(input logic [3:0] d);
        case (d)
            4'h0: hex_seg = 7'h40;
            4'h1: hex_seg = 7'h79;
            4'h2: hex_seg = 7'h24;
            4'h3: hex_seg = 7'h30;
            4'h4: hex_seg = 7'h19;
            4'h5: hex_seg = 7'h12;
            4'h6: hex_seg = 7'h02;
            4'h7: hex_seg = 7'h78;
            4'h8: hex_seg = 7'h00;
            4'h9: hex_seg = 7'h10;
            4'hA: hex_seg = 7'h08;
            4'hB: hex_seg = 7'h03;
            4'hC: hex_seg = 7'h46;
            4'hD: hex_seg = 7'h21;
            4'hE: hex_seg = 7'h06;
            default: hex_seg = 7'h0E;
        endcase
    endfunction

    logic [SCAN_DIV_W-1:0]       div_reg;
    logic                        tick;
    logic                        started_reg;
    logic [IDX_W-1:0]            idx_reg, idx_next;
    logic [NUM_DIGITS-1:0][3:0]  shadow_reg;
    logic                        overflow_reg, ovf_pend_reg;
    logic                        busy_reg;
    logic [CNT_W-1:0]            cnt_reg;
    logic [VALUE_W-1:0]          sh_reg;
    logic [BCD_W-1:0]            bcd_reg, bcd_adj, bcd_next, value_ext;
    logic [NUM_DIGITS:0]         upper_zero;
    logic [6:0]                  seg;
    logic [7:0]                  disp_low, display_next;
    logic [NUM_DIGITS-1:0]       onehot, digit_next;

    assign tick = &div_reg;
    assign busy = busy_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            assign bcd_adj[4*gi +: 4] = (bcd_reg[4*gi +: 4] >= 4'd5) ?
                                        bcd_reg[4*gi +: 4] + 4'd3 : bcd_reg[4*gi +: 4];
            // A digit is a leading zero when it and everything above it is zero.
            assign upper_zero[gi] = (shadow_reg[gi] == 4'd0) && upper_zero[gi+1];
        end
    endgenerate
    assign upper_zero[NUM_DIGITS] = 1'b1;
    assign bcd_next = {bcd_adj[BCD_W-2:0], sh_reg[VALUE_W-1]};

    always_comb begin
        value_ext = '0;
        value_ext[VALUE_W-1:0] = value;
    end

    always_comb begin
        if (!started_reg)
            idx_next = '0;
        else if (idx_reg == IDX_W'(NUM_DIGITS - 1))
            idx_next = '0;
        else
            idx_next = idx_reg + IDX_W'(1);
    end

    always_comb begin
        seg = 7'h7F;
        if (overflow_reg)
            seg = 7'h3F;
        else if (blank_lz && (idx_next != '0) && upper_zero[idx_next])
            seg = 7'h7F;
        else
            seg = hex_seg(shadow_reg[idx_next]);
        disp_low     = {~dp_mask[idx_next], seg};
        display_next = ACTIVE_LOW ? disp_low : ~disp_low;
        onehot       = NUM_DIGITS'(1) << idx_next;
        digit_next   = ACTIVE_LOW ? ~onehot : onehot;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_reg      <= '0;
            started_reg  <= 1'b0;
            idx_reg      <= '0;
            shadow_reg   <= '0;
            overflow_reg <= 1'b0;
            ovf_pend_reg <= 1'b0;
            busy_reg     <= 1'b0;
            cnt_reg      <= '0;
            sh_reg       <= '0;
            bcd_reg      <= '0;
            DISPLAY      <= DISP_OFF;
            DIGIT        <= DIGIT_OFF;
        end else begin
            div_reg <= div_reg + SCAN_DIV_W'(1);
            if (tick) begin
                started_reg <= 1'b1;
                idx_reg     <= idx_next;
                DISPLAY     <= display_next;
                DIGIT       <= digit_next;
            end
            if (load && !busy_reg) begin
                if (mode) begin
                    busy_reg     <= 1'b1;
                    cnt_reg      <= CNT_W'(VALUE_W - 1);
                    sh_reg       <= value;
                    bcd_reg      <= '0;
                    ovf_pend_reg <= (64'(value) > MAX_DEC);
                end else begin
                    shadow_reg   <= value_ext;
                    overflow_reg <= 1'b0;
                end
            end else if (busy_reg) begin
                bcd_reg <= bcd_next;
                sh_reg  <= sh_reg << 1;
                cnt_reg <= cnt_reg - CNT_W'(1);
                // Shadow is only touched once the full result is ready.
                if (cnt_reg == '0) begin
                    busy_reg     <= 1'b0;
                    shadow_reg   <= bcd_next;
                    overflow_reg <= ovf_pend_reg;
                end
            end
        end
    end
endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed bench for seven_seg_scanner with a fast scan divider (SCAN_DIV_W=4).
module tb_seven_seg_scanner;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [13:0] value = '0;
    logic        load = 1'b0;
    logic        mode = 1'b0;
    logic [3:0]  dp_mask = '0;
    logic        blank_lz = 1'b0;
    logic        busy;
    logic [7:0]  DISPLAY;
    logic [3:0]  DIGIT;

    int errors = 0;
    int checks = 0;

    seven_seg_scanner #(
        .NUM_DIGITS(4), .SCAN_DIV_W(4), .VALUE_W(14), .ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .rst(rst), .value(value), .load(load), .mode(mode),
        .dp_mask(dp_mask), .blank_lz(blank_lz), .busy(busy),
        .DISPLAY(DISPLAY), .DIGIT(DIGIT)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic do_load(input logic [13:0] v, input logic m);
        @(negedge clk);
        value = v;
        mode  = m;
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
    endtask

    task automatic busy_cycles(output int n);
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic next_tick(input string tag);
        logic [3:0] prev;
        int n;
        prev = DIGIT;
        n = 0;
        while (DIGIT === prev && n < 40) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(n < 40), 32'd1);
    endtask

    task automatic wait_digit(input string tag, input logic [3:0] d);
        int n;
        n = 0;
        while (DIGIT !== d && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_sel"}, 32'(DIGIT), 32'(d));
    endtask

    task automatic scan4(input string tag, input logic [7:0] d0, input logic [7:0] d1,
                         input logic [7:0] d2, input logic [7:0] d3);
        wait_digit({tag, "_d0"}, 4'b1110); check({tag, "_d0"}, 32'(DISPLAY), 32'(d0));
        wait_digit({tag, "_d1"}, 4'b1101); check({tag, "_d1"}, 32'(DISPLAY), 32'(d1));
        wait_digit({tag, "_d2"}, 4'b1011); check({tag, "_d2"}, 32'(DISPLAY), 32'(d2));
        wait_digit({tag, "_d3"}, 4'b0111); check({tag, "_d3"}, 32'(DISPLAY), 32'(d3));
    endtask

    initial begin
        int n;
        // 1. reset and first tick
        #1 rst = 1'b1;
        #1;
        check("rst_display", 32'(DISPLAY), 32'hFF);
        check("rst_digit", 32'(DIGIT), 32'hF);
        check("rst_busy", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (15) @(negedge clk);
        check("pre_tick_digit", 32'(DIGIT), 32'hF);
        @(negedge clk);
        check("first_tick_digit", 32'(DIGIT), 32'hE);
        check("first_tick_display", 32'(DISPLAY), 32'hC0);

        // 2. decimal 1234
        do_load(14'd1234, 1'b1);
        busy_cycles(n);
        check("busy_len_1234", 32'(n), 32'd14);
        next_tick("t2_tick");
        scan4("dec1234", 8'h99, 8'hB0, 8'hA4, 8'hF9);

        // 6. decimal point on digit 2 only
        dp_mask = 4'b0100;
        next_tick("t6_tick");
        scan4("dp", 8'h99, 8'hB0, 8'h24, 8'hF9);
        dp_mask = 4'b0000;

        // 4. overflow
        do_load(14'd12000, 1'b1);
        busy_cycles(n);
        check("busy_len_12000", 32'(n), 32'd14);
        next_tick("t4_tick");
        scan4("ovf", 8'hBF, 8'hBF, 8'hBF, 8'hBF);

        // 3. hex 0x3AF with and without blanking (also clears overflow)
        blank_lz = 1'b1;
        do_load(14'h3AF, 1'b0);
        check("hex_busy", 32'(busy), 32'd0);
        next_tick("t3_tick");
        scan4("hex_lz", 8'h8E, 8'h88, 8'hB0, 8'hFF);
        blank_lz = 1'b0;
        next_tick("t3b_tick");
        scan4("hex_nolz", 8'h8E, 8'h88, 8'hB0, 8'hC0);

        // 5. load during busy is ignored, no queueing
        do_load(14'd1234, 1'b1);
        repeat (3) @(negedge clk);
        do_load(14'd42, 1'b1);
        busy_cycles(n);
        repeat (3) @(negedge clk);
        check("no_queue_busy", 32'(busy), 32'd0);
        next_tick("t5_tick");
        scan4("ignored", 8'h99, 8'hB0, 8'hA4, 8'hF9);

        // 5. async reset mid-conversion
        do_load(14'd9999, 1'b1);
        repeat (4) @(negedge clk);
        check("mid_busy", 32'(busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_display", 32'(DISPLAY), 32'hFF);
        check("abort_digit", 32'(DIGIT), 32'hF);
        @(negedge clk);
        rst = 1'b0;
        blank_lz = 1'b1;
        repeat (15) @(negedge clk);
        check("abort_pre_tick", 32'(DIGIT), 32'hF);
        @(negedge clk);
        check("abort_tick_digit", 32'(DIGIT), 32'hE);
        check("abort_tick_display", 32'(DISPLAY), 32'hC0);
        wait_digit("abort_d1", 4'b1101);
        check("abort_d1_blank", 32'(DISPLAY), 32'hFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
